// File: rtl/nn_const_pkg.sv
// Shared constants and encodings for the constant-fetch path of the NN accelerator.
package nn_const_pkg;

  localparam int unsigned N_PIX = 784;
  localparam int unsigned N_L1  = 56;
  localparam int unsigned PIX_W = 10;
  localparam int unsigned L1_W  = 6;
  localparam int unsigned N_FETCH_KINDS = 4;

  typedef enum logic [1:0] {
    PH_B0 = 2'd0,
    PH_W0 = 2'd1,
    PH_B1 = 2'd2,
    PH_W1 = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_HANDOFF = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // One-hot request/valid vector ordered {w1, b1, w0, b0}.
  function automatic logic [N_FETCH_KINDS-1:0] phase_onehot(input phase_e p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/fetch_timeout_timer.sv
// Wait-cycle counter for an outstanding fetch; expired is high once TIMEOUT-1 cycles elapsed.
module fetch_timeout_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Saturating count; expired tracks count == LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + CW'(1);
      expired <= (count_q == (LAST - CW'(1)));
    end
  end

endmodule

// File: rtl/constant_fetch_sequencer.sv
// Sequences bias/weight fetches B0, W0 x N_PIX, B1, W1 x N_L1 against the constant memory controller.
module constant_fetch_sequencer #(
  parameter int unsigned N_PIX   = nn_const_pkg::N_PIX,
  parameter int unsigned N_L1    = nn_const_pkg::N_L1,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           b0_complete,
  input  logic                           w0_complete,
  input  logic                           b1_complete,
  input  logic                           w1_complete,
  input  logic                           data_ack,
  output logic                           b0_fetch,
  output logic                           w0_fetch,
  output logic                           b1_fetch,
  output logic                           w1_fetch,
  output logic [nn_const_pkg::PIX_W-1:0] pixel_no,
  output logic [nn_const_pkg::L1_W-1:0]  l1_no,
  output logic                           b0_valid,
  output logic                           w0_valid,
  output logic                           b1_valid,
  output logic                           w1_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  import nn_const_pkg::*;

  localparam int unsigned PW = nn_const_pkg::PIX_W;
  localparam int unsigned LW = nn_const_pkg::L1_W;
  localparam logic [PW-1:0] LAST_PIX = PW'(N_PIX - 1);
  localparam logic [LW-1:0] LAST_L1  = LW'(N_L1 - 1);

  state_e        state_q, state_n;
  phase_e        phase_q, phase_n;
  logic [PW-1:0] pix_q, pix_n;
  logic [LW-1:0] l1_q, l1_n;
  logic [3:0]    fetch_q, fetch_n;
  logic [3:0]    valid_q, valid_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          error_q, error_n;
  logic          last_q, last_n;
  logic [3:0]    complete_c;
  logic          expired;

  assign complete_c = {w1_complete, b1_complete, w0_complete, b0_complete};

  fetch_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_ISSUE),
    .enable  (state_q == ST_ISSUE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_B0;
      pix_q   <= '0;
      l1_q    <= '0;
      fetch_q <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      pix_q   <= pix_n;
      l1_q    <= l1_n;
      fetch_q <= fetch_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      error_q <= error_n;
      last_q  <= last_n;
    end
  end

  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    pix_n   = pix_q;
    l1_n    = l1_q;
    fetch_n = fetch_q;
    valid_n = valid_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    error_n = error_q;
    last_n  = last_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_n = ST_ISSUE;
          phase_n = PH_B0;
          pix_n   = '0;
          l1_n    = '0;
          fetch_n = phase_onehot(PH_B0);
          valid_n = '0;
          busy_n  = 1'b1;
          error_n = 1'b0;
          last_n  = 1'b0;
        end
      end
      ST_ISSUE: begin
        // A matching completion wins over a timeout landing on the same edge.
        if (complete_c[phase_q]) begin
          fetch_n = '0;
          valid_n = phase_onehot(phase_q);
          state_n = ST_HANDOFF;
        end else if (expired) begin
          fetch_n = '0;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_ERR;
        end
      end
      ST_HANDOFF: begin
        if (data_ack) begin
          valid_n = '0;
          state_n = ST_GAP;
          unique case (phase_q)
            PH_B0: phase_n = PH_W0;
            PH_W0: begin
              if (pix_q == LAST_PIX) phase_n = PH_B1;
              else                   pix_n   = pix_q + PW'(1);
            end
            PH_B1: phase_n = PH_W1;
            PH_W1: begin
              if (l1_q == LAST_L1) last_n = 1'b1;
              else                 l1_n   = l1_q + LW'(1);
            end
            default: phase_n = PH_B0;
          endcase
        end
      end
      ST_GAP: begin
        // One idle cycle so the controller sees a fresh rising request.
        if (last_q) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          state_n = ST_ISSUE;
          fetch_n = phase_onehot(phase_q);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign {w1_fetch, b1_fetch, w0_fetch, b0_fetch} = fetch_q;
  assign {w1_valid, b1_valid, w0_valid, b0_valid} = valid_q;
  assign pixel_no = pix_q;
  assign l1_no    = l1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_constant_fetch_sequencer.sv
// Directed bench: reset, full run with responder, backpressure, stray completes, mid-run reset, timeout.
module tb_constant_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] comp;
  logic       data_ack;
  logic       b0_fetch, w0_fetch, b1_fetch, w1_fetch;
  logic       b0_valid, w0_valid, b1_valid, w1_valid;
  logic [9:0] pixel_no;
  logic [5:0] l1_no;
  logic       busy, done, error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  constant_fetch_sequencer #(.N_PIX(784), .N_L1(56), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .b0_complete (comp[0]),
    .w0_complete (comp[1]),
    .b1_complete (comp[2]),
    .w1_complete (comp[3]),
    .data_ack    (data_ack),
    .b0_fetch    (b0_fetch),
    .w0_fetch    (w0_fetch),
    .b1_fetch    (b1_fetch),
    .w1_fetch    (w1_fetch),
    .pixel_no    (pixel_no),
    .l1_no       (l1_no),
    .b0_valid    (b0_valid),
    .w0_valid    (w0_valid),
    .b1_valid    (b1_valid),
    .w1_valid    (w1_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  function automatic logic [3:0] fetch_vec();
    return {w1_fetch, b1_fetch, w0_fetch, b0_fetch};
  endfunction

  function automatic logic [3:0] valid_vec();
    return {w1_valid, b1_valid, w0_valid, b0_valid};
  endfunction

  function automatic logic [31:0] all_out();
    return {5'd0, fetch_vec(), valid_vec(), busy, done, error, pixel_no, l1_no};
  endfunction

  function automatic logic [3:0] oh(input int ph);
    logic [3:0] one;
    one = 4'b0001;
    return one << ph;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: wait for the request, complete 3 cycles after it rose, then ack.
  task automatic fetch_step(input int ph, input int pix, input int l1, input int hold, input bit inject);
    int n;
    n = 0;
    while (fetch_vec() == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    check("fetch_onehot", 32'(fetch_vec()), 32'(oh(ph)));
    check("pixel_no", 32'(pixel_no), pix);
    check("l1_no", 32'(l1_no), l1);
    check("busy_run", 32'(busy), 1);
    if (hold > 0) data_ack = 1'b0;
    if (inject) begin
      comp  = 4'b1000;
      start = 1'b1;
    end
    tick();
    comp  = 4'b0000;
    start = 1'b0;
    check("fetch_hold1", 32'(fetch_vec()), 32'(oh(ph)));
    check("pix_stable", 32'(pixel_no), pix);
    check("l1_stable", 32'(l1_no), l1);
    check("valid_none", 32'(valid_vec()), 0);
    tick();
    check("fetch_hold2", 32'(fetch_vec()), 32'(oh(ph)));
    comp = oh(ph);
    tick();
    comp = 4'b0000;
    check("fetch_drop", 32'(fetch_vec()), 0);
    check("valid_up", 32'(valid_vec()), 32'(oh(ph)));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", 32'(valid_vec()), 32'(oh(ph)));
      check("bp_nofetch", 32'(fetch_vec()), 0);
      check("bp_pix", 32'(pixel_no), pix);
    end
    data_ack = 1'b1;
    tick();
    check("valid_clr", 32'(valid_vec()), 0);
    check("gap_low", 32'(fetch_vec()), 0);
    if (hold > 0) begin
      tick();
      check("refetch_2cyc", 32'(fetch_vec()), 32'(oh(ph)));
      check("refetch_pix", 32'(pixel_no), pix + 1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_b0", 32'(fetch_vec()), 32'h1);
    check("start_busy", 32'(busy), 1);
    check("start_err", 32'(error), 0);
    check("start_pix", 32'(pixel_no), 0);
    check("start_l1", 32'(l1_no), 0);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    comp     = 4'b0000;
    data_ack = 1'b1;

    // Reset held low while start toggles.
    for (int i = 0; i < 4; i++) begin
      tick();
      start = ~start;
      check("rst_outputs", all_out(), 0);
    end
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("idle_outputs", all_out(), 0);

    // Full run with backpressure at pixel 5 and a stray w1_complete/start at pixel 10.
    pulse_start();
    fetch_step(0, 0, 0, 0, 1'b0);
    for (int p = 0; p < 784; p++) fetch_step(1, p, 0, (p == 5) ? 20 : 0, p == 10);
    fetch_step(2, 783, 0, 0, 1'b0);
    for (int l = 0; l < 56; l++) fetch_step(3, 783, l, 0, 1'b0);
    tick();
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_fetch", 32'(fetch_vec()), 0);
    tick();
    check("done_single", 32'(done), 0);
    check("end_err", 32'(error), 0);
    check("end_pix", 32'(pixel_no), 783);
    check("end_l1", 32'(l1_no), 55);
    tick();
    check("idle_quiet", 32'({fetch_vec(), done, busy}), 0);

    // Mid-run reset at pixel 300.
    pulse_start();
    fetch_step(0, 0, 0, 0, 1'b0);
    for (int p = 0; p < 300; p++) fetch_step(1, p, 0, 0, 1'b0);
    tick();
    check("pix300_fetch", 32'(fetch_vec()), 32'h2);
    check("pix300_no", 32'(pixel_no), 300);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", all_out(), 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", all_out(), 0);

    // Restart and let B1 time out.
    pulse_start();
    fetch_step(0, 0, 0, 0, 1'b0);
    for (int p = 0; p < 784; p++) fetch_step(1, p, 0, 0, 1'b0);
    n = 0;
    while (b1_fetch !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("b1_rise", 32'(fetch_vec()), 32'h4);
    for (int i = 0; i < 63; i++) begin
      tick();
      check("to_wait_err", 32'(error), 0);
      check("to_wait_fetch", 32'(fetch_vec()), 32'h4);
    end
    tick();
    check("to_err", 32'(error), 1);
    check("to_fetch_low", 32'(fetch_vec()), 0);
    check("to_busy", 32'(busy), 0);
    tick();
    check("to_sticky", 32'(error), 1);
    pulse_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/constant_fetch_sequencer.md
CONSTANT_FETCH_SEQUENCER -- requirements
Module: constant_fetch_sequencer

Interface
REQ-001 Parameter N_PIX, default 784, SHALL set the number of layer-0 weight fetches (pixel count).
REQ-002 Parameter N_L1, default 56, SHALL set the number of layer-1 weight fetches (hidden-neuron count).
REQ-003 Parameter TIMEOUT, default 256, SHALL set the maximum cycles a fetch waits for its complete.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin one full constant-fetch run; sampled only in IDLE or ERR.
REQ-007 b0_complete, w0_complete, b1_complete, w1_complete  input  1 each  single-cycle completion pulses from the constant memory controller.
REQ-008 data_ack  input  1  downstream datapath has consumed the fetched register.
REQ-009 b0_fetch, w0_fetch, b1_fetch, w1_fetch  output  1 each  one-hot fetch requests, registered.
REQ-010 pixel_no  output  10  pixel index of the current w0 fetch.
REQ-011 l1_no  output  6  hidden-neuron index of the current w1 fetch.
REQ-012 b0_valid, w0_valid, b1_valid, w1_valid  output  1 each  fetched data is ready in the controller's output registers.
REQ-013 busy  output  1  high from the start acceptance until DONE.
REQ-014 done  output  1  one-cycle pulse at the end of the run.
REQ-015 error  output  1  sticky timeout flag.

Function
REQ-016 The block SHALL implement the states IDLE, ISSUE, HANDOFF, GAP, DONE and ERR, plus a phase register holding B0, W0, B1 or W1.
REQ-017 Fetch order SHALL be B0 once, W0 for pixel_no 0..N_PIX-1, B1 once, then W1 for l1_no 0..N_L1-1, for N_PIX+N_L1+2 fetches in total.
REQ-018 When start is sampled in IDLE, the block SHALL set phase=B0, pixel_no=0, l1_no=0 and busy=1, move to ISSUE, and drive b0_fetch high in the next cycle.
REQ-019 In ISSUE, exactly one fetch bit, the one matching the phase, SHALL be held high, and pixel_no and l1_no SHALL not change.
REQ-020 In ISSUE, a complete pulse matching the phase SHALL, at that edge, drop the fetch bit, raise the matching *_valid and move to HANDOFF.
REQ-021 A complete pulse that does not match the phase, or arrives in any state other than ISSUE, SHALL be ignored.
REQ-022 In HANDOFF, *_valid SHALL stay high until data_ack is sampled high; at that edge, *_valid SHALL clear, the index or phase SHALL advance and the state SHALL move to GAP.
REQ-023 GAP SHALL last exactly one cycle with all fetch bits low, so the controller detects each new request, including back-to-back W0 and W1 fetches.
REQ-024 After GAP, the block SHALL go to ISSUE if fetches remain, otherwise to DONE.
REQ-025 In W0, pixel_no SHALL increment on each ack and move to phase B1 after the ack for N_PIX-1; it then holds N_PIX-1.
REQ-026 In W1, l1_no SHALL increment on each ack; after the ack for N_L1-1 it holds N_L1-1 and the run ends.
REQ-027 DONE SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-028 A wait-cycle counter SHALL clear on entry to ISSUE; if it reaches TIMEOUT-1 without a matching complete, the block SHALL drop all fetch bits, set error=1 and busy=0, and enter ERR.
REQ-029 In ERR, start SHALL clear error and restart exactly as in REQ-018.
REQ-030 start SHALL be ignored in every state other than IDLE and ERR.
REQ-031 data_ack outside HANDOFF SHALL be ignored.

Reset
REQ-032 reset low SHALL immediately, without a clock edge, force state IDLE, phase B0 and all counters to 0.
REQ-033 reset low SHALL immediately force all outputs to 0, including pixel_no, l1_no, error and done.
REQ-034 An assertion of reset mid-run SHALL abandon the run; the next start SHALL begin at B0 with both indices 0.

Structure
REQ-035 N_PIX, N_L1, the output count (10) and the phase encoding SHALL reside in the shared package nn_const_pkg.
REQ-036 The timeout counter SHALL be a sub-module, fetch_timeout_timer, with clear, enable and expired signals.

Verification
REQ-037 Reset: hold reset low and toggle start -> all outputs 0 and no fetch asserted.
REQ-038 Full run: responder model completes 3 cycles after each fetch and data_ack is tied high -> 842 fetches in the B0, W0 x784, B1, W1 x56 order, pixel_no sweeping 0..783, l1_no sweeping 0..55, a single done pulse and error=0.
REQ-039 Protocol: for every fetch, the fetch bit is low for at least 1 cycle between requests, pixel_no and l1_no are stable while the fetch is high, and a w1_complete injected during W0 is ignored.
REQ-040 Backpressure: hold data_ack low for 20 cycles at pixel 5 -> w0_valid held high, no fetch issued, pixel_no=5; w0_fetch rises 2 cycles after the ack.
REQ-041 Timeout: TIMEOUT=64 and the responder never completes B1 -> error=1 64 cycles after b1_fetch rose, all fetch bits low; a following start clears error and reissues b0_fetch.
REQ-042 Reset mid-run: assert reset at pixel 300 -> outputs zero with no clock edge; the next start restarts at B0 with pixel_no=0.
